nn_layer_sequencer: RTL and testbench
=====================================

Name: nn_layer_sequencer

Overview:
- Control FSM that time-multiplexes the accelerator's single shared MAC datapath over one fully-connected MNIST layer.
- For each output neuron j, it issues N_IN sequential input and weight reads, aligns MAC enables to the memory read latency, then adds the bias and hands the result to the output buffer through a valid/ready handshake.
- Sits between the top-level command decode (start/abort) and the MAC/bias/ReLU datapath plus weight and activation memories.

Parameters:
- N_IN, 16: inputs per neuron (downsampled image pixels).
- N_OUT, 10: output neurons (digit classes).
- MEM_LAT, 1: read latency of activation/weight memories in cycles, ≥1.
- ACC_W, 16: width of the signed accumulator result from the datapath.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle request to run the layer; ignored unless idle.
- abort  in  1  cancel the layer; highest priority.
- busy  out  1  high from the cycle after an accepted start until DONE is left or abort takes effect.
- done  out  1  one-cycle pulse when the last neuron's result is accepted.
- rd_en  out  1  memory read strobe.
- in_addr  out  clog2(N_IN)  activation address i.
- w_addr  out  clog2(N_IN*N_OUT)  weight address j*N_IN+i, kept as a running counter (no multiplier).
- mac_clr  out  1  clears the accumulator.
- mac_en  out  1  accumulate the current product; equals rd_en delayed by MEM_LAT.
- bias_en  out  1  add bias[out_idx] to the accumulator.
- out_idx  out  clog2(N_OUT)  current neuron j; also the bias and output-buffer address.
- out_valid  out  1  result on the datapath accumulator is ready.
- out_ready  in  1  output buffer accepts the result.
- acc_in  in  ACC_W  signed accumulator value, valid while out_valid is high.
- class_idx  out  clog2(N_OUT)  argmax result (optional feature).
- class_valid  out  1  class_idx is valid (optional feature).

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters i, j and w_addr at 0, enable pipeline cleared.
- States:
  - IDLE: start goes to CLR, and j and w_addr are set to 0.
  - CLR: mac_clr=1 for one cycle, i=0, then FETCH.
  - FETCH: rd_en=1 for exactly N_IN cycles. in_addr=i and w_addr increment each cycle. After i==N_IN-1, go to DRAIN.
  - DRAIN: lasts MEM_LAT cycles while the mac_en pipeline empties, then BIAS.
  - BIAS: bias_en=1 for one cycle, then WRITE.
  - WRITE: out_valid=1 and held until out_ready, with out_idx, acc_in and addresses stable.
    - On handshake with j==N_OUT-1, go to DONE.
    - On handshake otherwise, j++ and go to CLR.
  - DONE: done=1 for one cycle, then IDLE.
- mac_en is a MEM_LAT-deep shift register of rd_en and is never asserted in CLR or BIAS.
- Latency per neuron is N_IN+MEM_LAT+3 cycles plus out_ready wait cycles. Defaults with out_ready tied high: 10*20+1 = 201 cycles from start to done.
- start while busy: ignored, no effect.
- abort:
  - In any non-IDLE state, the next state is IDLE.
  - rd_en, mac_en pipeline, bias_en and out_valid clear the next cycle.
  - No done pulse; counters reset.
  - abort in IDLE is a no-op. abort and start together: abort wins.
- out_valid drops on the cycle after the handshake. out_ready is ignored while out_valid=0.
- Reset mid-operation: immediate return to the reset state regardless of FSM state.

Optional Feature:
- Macro NN_SEQ_ARGMAX_EN.
- Defined:
  - On each WRITE handshake, compare acc_in signed against the running max.
  - j==0 always loads. A strictly greater value loads max and class_idx=j; ties keep the lower index.
  - class_valid rises with done and holds until the next accepted start or abort, both of which clear it.
- Undefined: class_idx=0 and class_valid=0 constant; no comparator or max register.

Decomposition:
- Package nn_pkg:
  - FSM state enum (IDLE, CLR, FETCH, DRAIN, BIAS, WRITE, DONE).
  - Default N_IN, N_OUT, ACC_W constants.
  - Address-width localparams derived with clog2.
- One natural sub-module, nn_argmax_tracker: max register, comparator and index, instantiated only under NN_SEQ_ARGMAX_EN.

Test Plan:
- Defaults, out_ready=1, single start:
  - rd_en high 16 cycles per neuron; w_addr runs 0..159 contiguously.
  - mac_en equals rd_en delayed 1 cycle.
  - 10 out_valid handshakes with out_idx 0..9.
  - done pulses exactly once, 201 cycles after start.
- Backpressure: out_ready low for 5 cycles at neuron 3.
  - out_valid, out_idx=3 and addresses stay stable.
  - No rd_en during the wait; done is delayed 5 cycles to cycle 206.
- Abort during FETCH of neuron 2 at i=7:
  - Next cycle busy=0 and rd_en=mac_en=0; no done.
  - A following start begins at w_addr=0, out_idx=0.
- start pulsed during busy, and start+abort in the same cycle:
  - No restart or counter disturbance while busy.
  - abort wins: the sequencer stays in (or returns to) IDLE.
- MEM_LAT=3 build: DRAIN lasts 3 cycles and the last mac_en occurs on the cycle before bias_en; total is 10*22+1 = 221 cycles.
- NN_SEQ_ARGMAX_EN: acc_in per neuron {-5,12,3,12,40,-1,0,40,7,2} gives class_idx=4 with class_valid at done; a new start clears class_valid.

Source files
------------

// File: rtl/nn_layer_sequencer_pkg.sv
// nn_pkg: shared types and default sizing for the fully-connected layer sequencer.
package nn_pkg;

    // Default layer geometry (MNIST downsampled input -> digit classes)
    localparam int unsigned N_IN_DEF    = 16;
    localparam int unsigned N_OUT_DEF   = 10;
    localparam int unsigned ACC_W_DEF   = 16;
    localparam int unsigned MEM_LAT_DEF = 1;

    // Address width for an index space of n entries; never narrower than one bit
    function automatic int unsigned addr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned IN_AW_DEF  = addr_w(N_IN_DEF);
    localparam int unsigned W_AW_DEF   = addr_w(N_IN_DEF * N_OUT_DEF);
    localparam int unsigned OUT_AW_DEF = addr_w(N_OUT_DEF);

    // Sequencer control states
    typedef enum logic [2:0] {
        IDLE,
        CLR,
        FETCH,
        DRAIN,
        BIAS,
        WRITE,
        DONE
    } seq_state_t;

endpackage

// File: rtl/nn_layer_sequencer_if.sv
// nn_layer_sequencer_if: memory-read, MAC-control and result-handshake bundle between
// the layer sequencer (master) and the MAC/bias/ReLU datapath plus memories (slave).
interface nn_layer_sequencer_if
    import nn_pkg::*;
#(
    parameter int unsigned N_IN  = N_IN_DEF,
    parameter int unsigned N_OUT = N_OUT_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF
);
    localparam int unsigned IN_AW  = addr_w(N_IN);
    localparam int unsigned W_AW   = addr_w(N_IN * N_OUT);
    localparam int unsigned OUT_AW = addr_w(N_OUT);

    logic                     rd_en;
    logic [IN_AW-1:0]         in_addr;
    logic [W_AW-1:0]          w_addr;
    logic                     mac_clr;
    logic                     mac_en;
    logic                     bias_en;
    logic [OUT_AW-1:0]        out_idx;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  acc_in;

    modport master (
        output rd_en, in_addr, w_addr, mac_clr, mac_en, bias_en, out_idx, out_valid,
        input  out_ready, acc_in
    );

    modport slave (
        input  rd_en, in_addr, w_addr, mac_clr, mac_en, bias_en, out_idx, out_valid,
        output out_ready, acc_in
    );

endinterface

// File: rtl/nn_layer_sequencer_argmax_tracker.sv
// nn_argmax_tracker: running signed maximum over the per-neuron results of one layer
// pass, reporting the winning neuron index once the last result has been accepted.
module nn_argmax_tracker #(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned IDX_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic                    first,
    input  logic                    finish,
    input  logic signed [ACC_W-1:0] value,
    input  logic [IDX_W-1:0]        idx,
    output logic [IDX_W-1:0]        class_idx,
    output logic                    class_valid
);

    logic signed [ACC_W-1:0] max_q;

    // Track max and its index; strict compare so ties keep the lower neuron index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q       <= '0;
            class_idx   <= '0;
            class_valid <= 1'b0;
        end else if (clear) begin
            max_q       <= '0;
            class_idx   <= '0;
            class_valid <= 1'b0;
        end else begin
            if (load && (first || (value > max_q))) begin
                max_q     <= value;
                class_idx <= idx;
            end
            if (finish) begin
                class_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: control FSM time-multiplexing one shared MAC datapath over a
// fully-connected layer (CLR -> FETCH x N_IN -> DRAIN x MEM_LAT -> BIAS -> WRITE per
// neuron). Optional argmax tracking is compiled in with `define NN_SEQ_ARGMAX_EN.
module nn_layer_sequencer
    import nn_pkg::*;
#(
    parameter int unsigned N_IN    = N_IN_DEF,
    parameter int unsigned N_OUT   = N_OUT_DEF,
    parameter int unsigned MEM_LAT = MEM_LAT_DEF,
    parameter int unsigned ACC_W   = ACC_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    nn_layer_sequencer_if.master        dp,
    output logic [addr_w(N_OUT)-1:0]    class_idx,
    output logic                        class_valid
);

    localparam int unsigned IN_AW   = addr_w(N_IN);
    localparam int unsigned W_AW    = addr_w(N_IN * N_OUT);
    localparam int unsigned OUT_AW  = addr_w(N_OUT);
    localparam int unsigned DRAIN_W = addr_w(MEM_LAT);

    if (MEM_LAT < 1 || ACC_W < 2) begin : g_bad_cfg
        $error("nn_layer_sequencer: MEM_LAT must be >= 1 and ACC_W >= 2");
    end

    seq_state_t          state;
    logic                rd_en_q;
    logic [IN_AW-1:0]    in_addr_q;
    logic [W_AW-1:0]     w_addr_q;
    logic                mac_clr_q;
    logic                bias_en_q;
    logic [OUT_AW-1:0]   out_idx_q;
    logic                out_valid_q;
    logic                busy_q;
    logic                done_q;
    logic [DRAIN_W-1:0]  drain_cnt_q;
    logic [MEM_LAT-1:0]  mac_pipe_q;

    logic abort_hit;
    logic start_hit;
    logic handshake;
    logic last_in;
    logic last_out;

    // Abort outranks everything but only matters outside IDLE; start+abort never starts
    assign abort_hit = abort && (state != IDLE);
    assign start_hit = start && !abort && (state == IDLE);
    assign handshake = (state == WRITE) && dp.out_ready && !abort;
    assign last_in   = (in_addr_q == IN_AW'(N_IN - 1));
    assign last_out  = (out_idx_q == OUT_AW'(N_OUT - 1));

    // Layer control FSM; every output is registered alongside the state transition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rd_en_q     <= 1'b0;
            in_addr_q   <= '0;
            w_addr_q    <= '0;
            mac_clr_q   <= 1'b0;
            bias_en_q   <= 1'b0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            drain_cnt_q <= '0;
        end else if (abort_hit) begin
            state       <= IDLE;
            rd_en_q     <= 1'b0;
            in_addr_q   <= '0;
            w_addr_q    <= '0;
            mac_clr_q   <= 1'b0;
            bias_en_q   <= 1'b0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            drain_cnt_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_hit) begin
                        state     <= CLR;
                        mac_clr_q <= 1'b1;
                        busy_q    <= 1'b1;
                        out_idx_q <= '0;
                        w_addr_q  <= '0;
                    end
                end
                CLR: begin
                    mac_clr_q <= 1'b0;
                    in_addr_q <= '0;
                    rd_en_q   <= 1'b1;
                    state     <= FETCH;
                end
                FETCH: begin
                    // w_addr runs on across neurons, so it already holds j*N_IN at the next CLR
                    w_addr_q <= w_addr_q + 1'b1;
                    if (last_in) begin
                        rd_en_q     <= 1'b0;
                        in_addr_q   <= '0;
                        drain_cnt_q <= '0;
                        state       <= DRAIN;
                    end else begin
                        in_addr_q <= in_addr_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q == DRAIN_W'(MEM_LAT - 1)) begin
                        bias_en_q <= 1'b1;
                        state     <= BIAS;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                    end
                end
                BIAS: begin
                    bias_en_q   <= 1'b0;
                    out_valid_q <= 1'b1;
                    state       <= WRITE;
                end
                WRITE: begin
                    if (handshake) begin
                        out_valid_q <= 1'b0;
                        if (last_out) begin
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            out_idx_q <= out_idx_q + 1'b1;
                            mac_clr_q <= 1'b1;
                            state     <= CLR;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // mac_en is rd_en delayed by the memory read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_pipe_q <= '0;
        end else if (abort_hit) begin
            mac_pipe_q <= '0;
        end else begin
            mac_pipe_q[0] <= rd_en_q;
            for (int unsigned k = 1; k < MEM_LAT; k++) begin
                mac_pipe_q[k] <= mac_pipe_q[k-1];
            end
        end
    end

    assign dp.rd_en     = rd_en_q;
    assign dp.in_addr   = in_addr_q;
    assign dp.w_addr    = w_addr_q;
    assign dp.mac_clr   = mac_clr_q;
    assign dp.mac_en    = mac_pipe_q[MEM_LAT-1];
    assign dp.bias_en   = bias_en_q;
    assign dp.out_idx   = out_idx_q;
    assign dp.out_valid = out_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;

`ifdef NN_SEQ_ARGMAX_EN
    logic am_clear;
    logic am_first;
    logic am_finish;

    assign am_clear  = start_hit || abort_hit;
    assign am_first  = (out_idx_q == '0);
    assign am_finish = handshake && last_out;

    nn_argmax_tracker #(
        .ACC_W (ACC_W),
        .IDX_W (OUT_AW)
    ) u_argmax (
        .clk         (clk),
        .rst         (rst),
        .clear       (am_clear),
        .load        (handshake),
        .first       (am_first),
        .finish      (am_finish),
        .value       (dp.acc_in),
        .idx         (out_idx_q),
        .class_idx   (class_idx),
        .class_valid (class_valid)
    );
`else
    assign class_idx   = '0;
    assign class_valid = 1'b0;
`endif

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb_nn_layer_sequencer: directed bench for nn_layer_sequencer (MEM_LAT=1 and MEM_LAT=3
// instances). Argmax checks are active when NN_SEQ_ARGMAX_EN is defined.
module tb_nn_layer_sequencer;
    import nn_pkg::*;

    localparam int unsigned N_IN  = N_IN_DEF;
    localparam int unsigned N_OUT = N_OUT_DEF;
    localparam int unsigned ACC_W = ACC_W_DEF;

    logic clk = 1'b0;
    logic rst, start, abort, out_ready;
    logic busy, done, class_valid;
    logic [3:0] class_idx;
    logic start3, abort3;
    logic busy3, done3, class_valid3;
    logic [3:0] class_idx3;
    logic mon_clr;
    int   cyc = 0;

    logic signed [ACC_W-1:0] acc_tab [0:15];

    nn_layer_sequencer_if #(.N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(ACC_W)) dp ();
    nn_layer_sequencer_if #(.N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(ACC_W)) dp3 ();

    nn_layer_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .MEM_LAT(1), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
        .dp(dp), .class_idx(class_idx), .class_valid(class_valid)
    );

    nn_layer_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .MEM_LAT(3), .ACC_W(ACC_W)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort3), .busy(busy3), .done(done3),
        .dp(dp3), .class_idx(class_idx3), .class_valid(class_valid3)
    );

    assign dp.out_ready  = out_ready;
    assign dp.acc_in     = acc_tab[dp.out_idx];
    assign dp3.out_ready = 1'b1;
    assign dp3.acc_in    = '0;

    always #5 clk = ~clk;

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor for the MEM_LAT=1 instance
    int rd_cnt, w_err, mac_err, hs_cnt, done_cnt;
    int hs_idx [0:15];
    logic [7:0] exp_w;
    logic prev_rd;
    always @(negedge clk) begin
        if (mon_clr) begin
            rd_cnt <= 0; w_err <= 0; mac_err <= 0; hs_cnt <= 0; done_cnt <= 0;
            exp_w <= '0; prev_rd <= 1'b0;
        end else begin
            if (dp.rd_en) begin
                rd_cnt <= rd_cnt + 1;
                if (dp.w_addr !== exp_w || dp.in_addr !== exp_w[3:0]) w_err <= w_err + 1;
                exp_w <= exp_w + 8'd1;
            end
            if (dp.mac_en !== prev_rd) mac_err <= mac_err + 1;
            prev_rd <= dp.rd_en;
            if (dp.out_valid && dp.out_ready) begin
                if (hs_cnt < 16) hs_idx[hs_cnt] <= int'(dp.out_idx);
                hs_cnt <= hs_cnt + 1;
            end
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    // Monitor for the MEM_LAT=3 instance; rd_hist3[k] is rd_en k+1 cycles ago
    int rd3_cnt, mac3_err, bias3_err, bias3_cnt;
    logic [3:0] rd_hist3;
    logic mac_prev3;
    always @(negedge clk) begin
        if (mon_clr) begin
            rd3_cnt <= 0; mac3_err <= 0; bias3_err <= 0; bias3_cnt <= 0;
            rd_hist3 <= '0; mac_prev3 <= 1'b0;
        end else begin
            if (dp3.rd_en) rd3_cnt <= rd3_cnt + 1;
            if (dp3.mac_en !== rd_hist3[2]) mac3_err <= mac3_err + 1;
            if (dp3.bias_en) begin
                bias3_cnt <= bias3_cnt + 1;
                if (!(rd_hist3 == 4'b1000 && mac_prev3 && !dp3.mac_en)) bias3_err <= bias3_err + 1;
            end
            rd_hist3  <= {rd_hist3[2:0], dp3.rd_en};
            mac_prev3 <= dp3.mac_en;
        end
    end

    task automatic pulse_start(input bit clr, output int t);
        @(posedge clk); #1;
        start = 1'b1;
        mon_clr = clr;
        t = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        mon_clr = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen, output int at);
        seen = 1'b0;
        at = 0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    int t0, tdone, tx, stab_err;
    bit seen, found;
    logic [7:0] wa_cap;
    logic [3:0] ia_cap;

    initial begin
        acc_tab = '{-16'sd5, 16'sd12, 16'sd3, 16'sd12, 16'sd40, -16'sd1, 16'sd0, 16'sd40,
                    16'sd7, 16'sd2, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        start3 = 1'b0; abort3 = 1'b0; mon_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", dp.rd_en, 0);
        check("rst_mac_en", dp.mac_en, 0);
        check("rst_mac_clr", dp.mac_clr, 0);
        check("rst_out_valid", dp.out_valid, 0);
        check("rst_w_addr", dp.w_addr, 0);
        check("rst_out_idx", dp.out_idx, 0);
        check("rst_class_valid", class_valid, 0);

        // Full layer, out_ready high
        pulse_start(1'b1, t0);
        @(negedge clk);
        check("run1_busy_after_start", busy, 1);
        check("run1_mac_clr", dp.mac_clr, 1);
        wait_done(400, seen, tdone);
        check("run1_done_seen", seen, 1);
        check("run1_latency", tdone - t0, 201);
        check("run1_busy_in_done", busy, 1);
`ifdef NN_SEQ_ARGMAX_EN
        check("argmax_class_valid", class_valid, 1);
        check("argmax_class_idx", class_idx, 4);
`else
        check("run1_class_valid", class_valid, 0);
        check("run1_class_idx", class_idx, 0);
`endif
        repeat (3) @(negedge clk);
        check("run1_done_cnt", done_cnt, 1);
        check("run1_rd_cnt", rd_cnt, 160);
        check("run1_addr_err", w_err, 0);
        check("run1_mac_align", mac_err, 0);
        check("run1_hs_cnt", hs_cnt, 10);
        for (int k = 0; k < 10; k++) check("run1_hs_idx", hs_idx[k], k);
        check("run1_busy_end", busy, 0);

        // Backpressure: 5 stall cycles at neuron 3
        pulse_start(1'b1, t0);
`ifdef NN_SEQ_ARGMAX_EN
        check("argmax_start_clears", class_valid, 0);
`endif
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (dp.bias_en && dp.out_idx == 4'd3) begin found = 1'b1; break; end
        end
        check("bp_bias3_found", found, 1);
        @(posedge clk); #1 out_ready = 1'b0;
        stab_err = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (n == 0) begin wa_cap = dp.w_addr; ia_cap = dp.in_addr; end
            if (!dp.out_valid || dp.out_idx != 4'd3 || dp.w_addr != wa_cap ||
                dp.in_addr != ia_cap || dp.rd_en || dp.mac_en) stab_err++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        if (!dp.out_valid || dp.out_idx != 4'd3 || dp.w_addr != wa_cap) stab_err++;
        check("bp_stable", stab_err, 0);
        @(negedge clk);
        check("bp_valid_drop", dp.out_valid, 0);
        check("bp_next_idx", dp.out_idx, 4);
        wait_done(400, seen, tdone);
        check("bp_done_seen", seen, 1);
        check("bp_latency", tdone - t0, 206);
        repeat (2) @(negedge clk);
        check("bp_hs_cnt", hs_cnt, 10);
        check("bp_rd_cnt", rd_cnt, 160);
        check("bp_addr_err", w_err, 0);

        // Abort during FETCH of neuron 2 at i=7
        pulse_start(1'b1, t0);
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (dp.rd_en && dp.out_idx == 4'd2 && dp.in_addr == 4'd7) begin found = 1'b1; break; end
        end
        check("abort_point_found", found, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_rd_en", dp.rd_en, 0);
        check("abort_mac_en", dp.mac_en, 0);
        check("abort_w_addr", dp.w_addr, 0);
        check("abort_out_idx", dp.out_idx, 0);
        repeat (20) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        check("abort_stays_idle", busy, 0);

        // Restart after abort, with a stray start while busy
        pulse_start(1'b1, t0);
        found = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (dp.rd_en) begin found = 1'b1; break; end
        end
        check("restart_fetch_found", found, 1);
        check("restart_w_addr", dp.w_addr, 0);
        check("restart_in_addr", dp.in_addr, 0);
        check("restart_out_idx", dp.out_idx, 0);
        repeat (40) @(negedge clk);
        pulse_start(1'b0, tx);
        wait_done(400, seen, tdone);
        check("busy_start_done_seen", seen, 1);
        check("busy_start_latency", tdone - t0, 201);
        repeat (2) @(negedge clk);
        check("busy_start_done_cnt", done_cnt, 1);
        check("busy_start_rd_cnt", rd_cnt, 160);
        check("busy_start_addr_err", w_err, 0);

        // start+abort together in IDLE
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("idle_start_abort_busy", busy, 0);
        check("idle_start_abort_clr", dp.mac_clr, 0);

        // start+abort together while busy
        pulse_start(1'b1, t0);
        repeat (10) @(negedge clk);
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("busy_start_abort_busy", busy, 0);
        check("busy_start_abort_rd_en", dp.rd_en, 0);

        // Asynchronous reset mid-layer
        pulse_start(1'b1, t0);
        repeat (30) @(negedge clk);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_rd_en", dp.rd_en, 0);
        check("async_rst_w_addr", dp.w_addr, 0);
        check("async_rst_out_idx", dp.out_idx, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", busy, 0);

        // MEM_LAT=3 instance
        @(posedge clk); #1 start3 = 1'b1; mon_clr = 1'b1; t0 = cyc;
        @(posedge clk); #1 start3 = 1'b0; mon_clr = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (done3) begin seen = 1'b1; tdone = cyc; break; end
        end
        check("lat3_done_seen", seen, 1);
        check("lat3_latency", tdone - t0, 221);
        repeat (2) @(negedge clk);
        check("lat3_rd_cnt", rd3_cnt, 160);
        check("lat3_mac_align", mac3_err, 0);
        check("lat3_drain_bias", bias3_err, 0);
        check("lat3_bias_cnt", bias3_cnt, 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
